dff_input_debouncer: RTL

Front-end conditioning stage that drives the D input of the team's D flip-flop blocks from a raw asynchronous source such as a switch, button or external pin. It synchronises the source into the CLK domain and rejects glitches shorter than a programmable stable window. It presents a clean level (Q/QN) plus single-cycle RISE/FALL strobes to the downstream flip-flop and control logic.

---
 rtl/dff_pkg.sv | 25 ++
 rtl/sync_chain.sv | 27 ++
 rtl/dff_input_debouncer.sv | 116 +++++++++++
 3 files changed

// File: rtl/dff_pkg.sv
// Shared definitions for the D flip-flop front-end blocks: debouncer state
// encoding and the supported synchroniser depth range.
package dff_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } dbnc_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Resting state that matches a given debounced level.
  function automatic dbnc_state_e idle_for(input logic level);
    return level ? IDLE_HI : IDLE_LO;
  endfunction

  // Qualifying state entered when the input disagrees with a given level.
  function automatic dbnc_state_e chk_for(input logic level);
    return level ? CHK_LO : CHK_HI;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Reset-to-0 flop chain that brings an asynchronous signal into the CLK domain.
// Reusable wherever an external input enters the design.
module sync_chain
  import dff_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [SYNC_STAGES-1:0] stages_r;

  // Shift the raw input through the chain; stage 0 is the only flop touching D.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stages_r <= {SYNC_STAGES{1'b0}};
    end else begin
      stages_r <= {stages_r[SYNC_STAGES-2:0], D};
    end
  end

  assign Q = stages_r[SYNC_STAGES-1];

endmodule

// File: rtl/dff_input_debouncer.sv
// Synchronises a raw input and only follows it once it has held a new level
// for STABLE_CYCLES consecutive enabled samples; emits level plus edge strobes.
module dff_input_debouncer
  import dff_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic D_IN,
  input  logic EN,
  output logic Q,
  output logic QN,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  localparam int CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync_s;
  dbnc_state_e          state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 q_r;
  logic                 qn_r;
  logic                 rise_r;
  logic                 fall_r;
  logic                 busy_r;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK(CLK),
    .RST(RST),
    .D  (D_IN),
    .Q  (sync_s)
  );

  // Debounce FSM with the stability counter and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= IDLE_LO;
      cnt_r   <= CNT_ZERO;
      q_r     <= 1'b0;
      qn_r    <= 1'b1;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (!EN) begin
        // Disabling abandons any qualification; the level itself is held.
        state_r <= idle_for(q_r);
        cnt_r   <= CNT_ZERO;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE_LO, IDLE_HI: begin
            if (sync_s == q_r) begin
              cnt_r  <= CNT_ZERO;
              busy_r <= 1'b0;
            end else if (STABLE_CYCLES == 1) begin
              q_r     <= ~q_r;
              qn_r    <= q_r;
              rise_r  <= ~q_r;
              fall_r  <= q_r;
              state_r <= idle_for(~q_r);
              cnt_r   <= CNT_ZERO;
              busy_r  <= 1'b0;
            end else begin
              state_r <= chk_for(q_r);
              cnt_r   <= CNT_ONE;
              busy_r  <= 1'b1;
            end
          end
          CHK_HI, CHK_LO: begin
            if (sync_s == q_r) begin
              state_r <= idle_for(q_r);
              cnt_r   <= CNT_ZERO;
              busy_r  <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
              q_r     <= ~q_r;
              qn_r    <= q_r;
              rise_r  <= ~q_r;
              fall_r  <= q_r;
              state_r <= idle_for(~q_r);
              cnt_r   <= CNT_ZERO;
              busy_r  <= 1'b0;
            end else begin
              cnt_r  <= cnt_r + CNT_ONE;
              busy_r <= 1'b1;
            end
          end
          default: begin
            state_r <= idle_for(q_r);
            cnt_r   <= CNT_ZERO;
            qn_r    <= ~q_r;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q    = q_r;
  assign QN   = qn_r;
  assign RISE = rise_r;
  assign FALL = fall_r;
  assign BUSY = busy_r;

endmodule
